mem_bus_arbiter: RTL

Arbitrates the pipeline's single memory bus between the fetch stage (instruction reads) and the memory stage (data loads and stores). It latches the granted request, runs the address/data handshake on the bus, and returns read data to the owning side. It also produces per-side stall signals that freeze the corresponding pipeline registers until the access completes. It sits between the pipeline stages and the bus interface.

---
 rtl/mem_bus_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the fetch side (I) and the
// memory side (D). Grants in IDLE, drives the request in REQ, waits for the
// response in WAIT, then returns read data to the owner with a one-cycle
// pulse. D wins collisions. Optional macro MEM_ARB_FAIR_EN adds a starvation
// counter that forces an I grant after STARVE_LIMIT consecutive D grants.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_resp_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_size,
  output logic        d_resp_ok,
  output logic [31:0] d_rdata,
  output logic        i_stall,
  output logic        d_stall,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  output logic [2:0]  bus_size,
  output logic        bus_write,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);
  // msize_t encoding: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes
  localparam logic [2:0] MSIZE4 = 3'd2;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]  bus_size_q, bus_size_d;
  logic        i_resp_ok_q, i_resp_ok_d;
  logic        d_resp_ok_q, d_resp_ok_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic i_elig, d_elig, grant_i, grant_d, done;

  // a side being answered this cycle is masked so it cannot be re-granted
  assign i_elig = i_req & ~i_resp_ok_q;
  assign d_elig = d_req & ~d_resp_ok_q;

`ifdef MEM_ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q, starve_d;
  logic          starve_hit;

  assign starve_hit = (starve_q == CW'(STARVE_LIMIT));

  // grant choice: D first unless I has waited out STARVE_LIMIT D grants
  always_comb begin
    grant_i = (state_q == S_IDLE) & i_elig & (~d_elig | starve_hit);
    grant_d = (state_q == S_IDLE) & d_elig & ~grant_i;
  end

  // starvation counter: counts D grants that jumped a waiting I
  always_comb begin
    starve_d = starve_q;
    if (grant_i)
      starve_d = '0;
    else if (grant_d) begin
      if (!i_elig)         starve_d = '0;
      else if (!starve_hit) starve_d = starve_q + 1'b1;
    end
  end

  // starvation counter register
  always_ff @(posedge clk) begin
    if (!resetn) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`else
  // grant choice: strict D priority
  always_comb begin
    grant_d = (state_q == S_IDLE) & d_elig;
    grant_i = (state_q == S_IDLE) & i_elig & ~d_elig;
  end
`endif

  assign done = ((state_q == S_REQ) & bus_addr_ok & bus_data_ok) |
                ((state_q == S_WAIT) & bus_data_ok);

  // next state, payload latch at grant, response capture at completion
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    bus_size_d  = bus_size_q;
    i_resp_ok_d = 1'b0;
    d_resp_ok_d = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          owner_d     = OWN_D;
          bus_addr_d  = d_addr;
          bus_wstrb_d = d_wstrb;
          bus_wdata_d = d_wdata;
          bus_size_d  = d_size;
          state_d     = S_REQ;
        end else if (grant_i) begin
          owner_d     = OWN_I;
          bus_addr_d  = i_addr;
          bus_wstrb_d = 4'b0000;
          bus_wdata_d = 32'h0;
          bus_size_d  = MSIZE4;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_addr_ok) state_d = bus_data_ok ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (bus_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      if (owner_q == OWN_D) begin
        d_resp_ok_d = 1'b1;
        d_rdata_d   = bus_rdata;
      end else begin
        i_resp_ok_d = 1'b1;
        i_rdata_d   = bus_rdata;
      end
    end
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_I;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      bus_size_q  <= '0;
      i_resp_ok_q <= 1'b0;
      d_resp_ok_q <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      bus_size_q  <= bus_size_d;
      i_resp_ok_q <= i_resp_ok_d;
      d_resp_ok_q <= d_resp_ok_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus_req   = (state_q == S_REQ);
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_size  = bus_size_q;
  assign bus_write = |bus_wstrb_q;
  assign i_resp_ok = i_resp_ok_q;
  assign d_resp_ok = d_resp_ok_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_stall   = i_req & ~i_resp_ok_q;
  assign d_stall   = d_req & ~d_resp_ok_q;
endmodule
